// File: rtl/vwu_reqrsp_mem_responder.sv
// Core-data reqrsp responder onto a 1-cycle single-port SRAM.
// In-order responses through a credit-managed fall-through buffer.
package vwu_reqrsp_pkg;

  localparam logic [3:0] AMONone = 4'h0;
  localparam logic [3:0] AMOSwap = 4'h1;
  localparam logic [3:0] AMOAdd  = 4'h2;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  size;
  } core_data_req_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } core_data_rsp_chan_t;

  typedef struct packed {
    core_data_req_chan_t q;
    logic                q_valid;
    logic                p_ready;
  } core_data_req_t;

  typedef struct packed {
    core_data_rsp_chan_t p;
    logic                p_valid;
    logic                q_ready;
  } core_data_rsp_t;

endpackage

module vwu_reqrsp_mem_responder
  import vwu_reqrsp_pkg::*;
#(
  parameter int unsigned NumWords = 128,
  parameter logic [31:0] BaseAddr = 32'h0002_0000,
  parameter int unsigned RspDepth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  core_data_req_t              req_i,
  output core_data_rsp_t              rsp_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(NumWords)-1:0] mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int unsigned AW = $clog2(NumWords);
  localparam int unsigned PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CW = $clog2(RspDepth + 1);
  localparam int unsigned OW = CW + 1;
  localparam logic [31:0] AddrMask = ~(32'(NumWords * 4) - 32'd1);

  logic          ifl_vld_q, ifl_vld_d;
  logic          ifl_we_q, ifl_we_d;
  logic          ifl_err_q, ifl_err_d;
  logic [31:0]   fifo_data_q [RspDepth];
  logic          fifo_err_q [RspDepth];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          legal;
  logic          accept;
  logic          q_ready;
  logic          p_valid;
  logic          pop;
  logic          push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [31:0]   ifl_data;
  logic [OW-1:0] outst;
  logic [1:0]    unused_size;

  assign unused_size = req_i.q.size;

  always_comb begin
    legal = ((req_i.q.addr & AddrMask) == BaseAddr)
         && (req_i.q.amo == AMONone);
    ifl_data = '0;
    if (ifl_vld_q && !ifl_we_q && !ifl_err_q) begin
      ifl_data = mem_rdata_i;
    end
    fifo_empty = (cnt_q == '0);
    p_valid = !fifo_empty || ifl_vld_q;
    pop = p_valid && req_i.p_ready;
    fifo_pop = !fifo_empty && req_i.p_ready;
    // Fall-through: an in-flight response only lands in the FIFO when
    // it cannot leave straight away.
    push = ifl_vld_q && !(fifo_empty && req_i.p_ready);
    outst = {{CW{1'b0}}, ifl_vld_q}
          + {1'b0, cnt_q}
          - {{CW{1'b0}}, pop};
    q_ready = rst_ni && (outst < OW'(RspDepth));
    accept = req_i.q_valid && q_ready;
  end

  always_comb begin
    mem_req_o = accept && legal;
    mem_we_o = req_i.q.write;
    mem_addr_o = req_i.q.addr[2 +: AW];
    mem_wdata_o = req_i.q.data;
    mem_be_o = req_i.q.strb;
  end

  always_comb begin
    rsp_o = '0;
    rsp_o.q_ready = q_ready;
    rsp_o.p_valid = p_valid;
    if (fifo_empty) begin
      rsp_o.p.data = ifl_data;
      rsp_o.p.error = ifl_vld_q && ifl_err_q;
    end else begin
      rsp_o.p.data = fifo_data_q[rptr_q];
      rsp_o.p.error = fifo_err_q[rptr_q];
    end
  end

  always_comb begin
    ifl_vld_d = accept;
    ifl_we_d = ifl_we_q;
    ifl_err_d = ifl_err_q;
    if (accept) begin
      ifl_we_d = req_i.q.write;
      ifl_err_d = !legal;
    end
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = (wptr_q == PW'(RspDepth - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rptr_d = (rptr_q == PW'(RspDepth - 1)) ? '0 : rptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(fifo_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifl_vld_q <= 1'b0;
      ifl_we_q <= 1'b0;
      ifl_err_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RspDepth); i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i] <= 1'b0;
      end
    end else begin
      ifl_vld_q <= ifl_vld_d;
      ifl_we_q <= ifl_we_d;
      ifl_err_q <= ifl_err_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      if (push) begin
        fifo_data_q[wptr_q] <= ifl_data;
        fifo_err_q[wptr_q] <= ifl_err_q;
      end
    end
  end

  // Credits keep in-flight plus buffered within RspDepth.
  no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt_q == CW'(RspDepth)))
  );

endmodule

// File: tb/tb_vwu_reqrsp_mem_responder.sv
// Randomized self-checking bench for vwu_reqrsp_mem_responder.
// Scoreboard model works on plain word memory and response queues.
module tb_vwu_reqrsp_mem_responder;
  import vwu_reqrsp_pkg::*;

  localparam int NW = 128;
  localparam logic [31:0] BASE = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  core_data_req_t req;
  core_data_rsp_t rsp;
  logic mem_req, mem_we;
  logic [6:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic [31:0] sram [NW];

  int checks = 0;
  int errors = 0;
  int unstable_n = 0;

  typedef struct packed {
    logic req;
    logic we;
    logic [6:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
  } acc_t;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  acc_t accx_q[$];
  acc_t acco_q[$];
  logic [31:0] mem_m [NW];
  logic hold_v = 1'b0;
  logic [32:0] hold_p;

  always #5 clk = ~clk;

  vwu_reqrsp_mem_responder #(
    .NumWords(NW), .BaseAddr(BASE), .RspDepth(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .rsp_o(rsp),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  // SRAM: read data is garbage except one cycle after a read
  always @(posedge clk) begin
    if (mem_req && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= (mem_req && !mem_we) ? sram[mem_addr] : $urandom;
  end

  always @(negedge clk) begin : monitor
    logic [31:0] off;
    logic lg;
    logic [31:0] w;
    if (!rst_n) begin
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      hold_v = 1'b0;
    end else begin
      if (hold_v && (!rsp.p_valid || {rsp.p.error, rsp.p.data} !== hold_p))
        unstable_n++;
      if (rsp.p_valid && req.p_ready)
        obs_q.push_back({rsp.p.error, rsp.p.data});
      hold_v = rsp.p_valid && !req.p_ready;
      hold_p = {rsp.p.error, rsp.p.data};
      if (req.q_valid && rsp.q_ready) begin
        off = req.q.addr - BASE;
        lg = (off < 32'(NW * 4)) && (req.q.amo == AMONone);
        w = lg ? mem_m[off[8:2]] : 32'h0;
        if (lg && req.q.write) begin
          for (int b = 0; b < 4; b++)
            if (req.q.strb[b]) w[8*b +: 8] = req.q.data[8*b +: 8];
          mem_m[off[8:2]] = w;
          exp_q.push_back({1'b0, 32'h0});
        end else if (lg) begin
          exp_q.push_back({1'b0, w});
        end else begin
          exp_q.push_back({1'b1, 32'h0});
        end
        accx_q.push_back(acc_t'{lg, req.q.write, off[8:2],
                                req.q.data, req.q.strb});
        acco_q.push_back(acc_t'{mem_req, mem_we, mem_addr,
                                mem_wdata, mem_be});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic wr,
                      input logic [3:0] amo, input logic [31:0] d,
                      input logic [3:0] s, output int waits);
    req.q.addr = a;
    req.q.write = wr;
    req.q.amo = amo;
    req.q.data = d;
    req.q.strb = s;
    req.q.size = 2'd2;
    req.q_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rsp.q_ready) break;
      waits++;
      if (waits >= 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout addr=%h q_ready=0 required 1", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    req.q_valid = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    req.q.addr = BASE;
    req.q_valid = 1'b1;
    req.p_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (rsp.q_ready !== 1'b0) begin
      errors++; $display("FAIL rst_q_ready got %b required 0", rsp.q_ready);
    end
    checks++;
    if (rsp.p_valid !== 1'b0) begin
      errors++; $display("FAIL rst_p_valid got %b required 0", rsp.p_valid);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mem_req got %b required 0", mem_req);
    end
    checks++;
    if (rsp.p !== '0) begin
      errors++; $display("FAIL rst_p got %h required 0", rsp.p);
    end
    req.q_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp.q_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_q_ready got %b required 1", rsp.q_ready);
    end
    checks++;
    if (rsp.p_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_p_valid got %b required 0", rsp.p_valid);
    end
  endtask

  task automatic test_fill();
    int w, maxw;
    maxw = 0;
    req.p_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      send(BASE + 32'(i * 4), 1'b1, AMONone, $urandom, 4'hF, w);
      if (w > maxw) maxw = w;
    end
    checks++;
    if (maxw != 0) begin
      errors++; $display("FAIL fill_stall got %0d waits required 0", maxw);
    end
  endtask

  task automatic test_single_read();
    int w;
    req.p_ready = 1'b1;
    send(BASE + 32'h10, 1'b1, AMONone, 32'hDEADBEEF, 4'hF, w);
    req.q.addr = BASE + 32'h10;
    req.q.write = 1'b0;
    req.q_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'd4) begin
      errors++;
      $display("FAIL read_mem_port got req=%b we=%b addr=%0d required 1 0 4",
               mem_req, mem_we, mem_addr);
    end
    @(posedge clk);
    #1 req.q_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'hDEADBEEF
        || rsp.p.error !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp got v=%b d=%h e=%b required 1 deadbeef 0",
               rsp.p_valid, rsp.p.data, rsp.p.error);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_strobe();
    int w;
    req.p_ready = 1'b1;
    send(BASE + 32'h40, 1'b1, AMONone, 32'hFFFFFFFF, 4'hF, w);
    send(BASE + 32'h40, 1'b1, AMONone, 32'h11223344, 4'h5, w);
    req.q.addr = BASE + 32'h40;
    req.q.write = 1'b0;
    req.q_valid = 1'b1;
    @(posedge clk);
    #1 req.q_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp.p_valid !== 1'b1 || rsp.p.data !== 32'hFF22FF44) begin
      errors++;
      $display("FAIL strobe_rsp got v=%b d=%h required 1 ff22ff44",
               rsp.p_valid, rsp.p.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    req.p_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        req.q.addr = BASE + 32'($urandom_range(0, NW - 1) * 4);
        req.q.write = 1'b0;
        req.q.amo = AMONone;
        req.q_valid = 1'b1;
      end else begin
        req.q_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (rsp.q_ready !== 1'b1) begin
          errors++; $display("FAIL stream_q_ready[%0d] got %b required 1", i, rsp.q_ready);
        end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (rsp.p_valid !== 1'b1) begin
          errors++; $display("FAIL stream_p_valid[%0d] got %b required 1", i, rsp.p_valid);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic tk, got3;
    logic [5:0] pv;
    acc = 0;
    got3 = 1'b0;
    pv = '0;
    req.p_ready = 1'b0;
    req.q.addr = BASE + 32'h20;
    req.q.write = 1'b0;
    req.q.amo = AMONone;
    req.q_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tk = rsp.q_ready;
      @(posedge clk);
      #1;
      if (tk) begin
        acc++;
        req.q.addr = req.q.addr + 32'h4;
      end
    end
    checks++;
    if (acc != 2) begin
      errors++; $display("FAIL bp_accepted got %0d required 2", acc);
    end
    checks++;
    if (rsp.q_ready !== 1'b0) begin
      errors++; $display("FAIL bp_q_ready got %b required 0", rsp.q_ready);
    end
    req.p_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pv[c] = rsp.p_valid;
      tk = req.q_valid && rsp.q_ready;
      @(posedge clk);
      #1;
      if (tk) begin
        got3 = 1'b1;
        req.q_valid = 1'b0;
      end
    end
    checks++;
    if (pv[3:0] !== 4'b0111) begin
      errors++; $display("FAIL bp_drain got %b required 0111", pv[3:0]);
    end
    checks++;
    if (got3 !== 1'b1) begin
      errors++; $display("FAIL bp_third_accept got %b required 1", got3);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5];
    logic [3:0] am [5];
    logic il [5];
    ea = '{BASE + 32'h10, BASE + 32'h200, BASE + 32'h44, BASE, BASE + 32'h1FC};
    am = '{AMONone, AMONone, AMONone, AMOAdd, AMONone};
    il = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    req.p_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        req.q.addr = ea[i];
        req.q.amo = am[i];
        req.q.write = 1'b0;
        req.q.data = $urandom;
        req.q.strb = 4'hF;
        req.q_valid = 1'b1;
      end else begin
        req.q_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 5) begin
        checks++;
        if (rsp.q_ready !== 1'b1 || mem_req !== !il[i]) begin
          errors++;
          $display("FAIL err_mem_req[%0d] got rdy=%b req=%b required 1 %b",
                   i, rsp.q_ready, mem_req, !il[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (rsp.p_valid !== 1'b1 || rsp.p.error !== il[i-1]
            || (il[i-1] && rsp.p.data !== 32'h0)) begin
          errors++;
          $display("FAIL err_rsp[%0d] got v=%b e=%b d=%h required 1 %b",
                   i - 1, rsp.p_valid, rsp.p.error, rsp.p.data, il[i-1]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    int outs, r;
    logic tk, epv, eqr;
    outs = 0;
    req.q_valid = 1'b0;
    req.p_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      req.p_ready = ($urandom_range(0, 3) != 0);
      if (!req.q_valid && $urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, 9);
        if (r < 8)
          req.q.addr = BASE + 32'($urandom_range(0, NW - 1) * 4)
                     + 32'($urandom_range(0, 3));
        else if (r == 8)
          req.q.addr = BASE + 32'(NW * 4) + 32'($urandom_range(0, 1023) * 4);
        else
          req.q.addr = BASE - 32'($urandom_range(1, 64) * 4);
        req.q.amo = ($urandom_range(0, 9) == 0) ?
                    4'($urandom_range(1, 15)) : AMONone;
        req.q.write = 1'($urandom_range(0, 1));
        req.q.data = $urandom;
        req.q.strb = 4'($urandom);
        req.q.size = 2'($urandom);
        req.q_valid = 1'b1;
      end
      @(negedge clk);
      epv = (outs > 0);
      eqr = ((outs - int'(epv && req.p_ready)) < 2);
      checks++;
      if (rsp.p_valid !== epv || rsp.q_ready !== eqr) begin
        errors++;
        $display("FAIL rand_credit[%0d] got v=%b rdy=%b required %b %b",
                 c, rsp.p_valid, rsp.q_ready, epv, eqr);
      end
      tk = req.q_valid && rsp.q_ready;
      outs = outs + int'(tk) - int'(epv && req.p_ready);
      @(posedge clk);
      #1;
      if (tk) req.q_valid = 1'b0;
    end
    req.q_valid = 1'b0;
    req.p_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int w;
    req.p_ready = 1'b0;
    send(BASE + 32'h10, 1'b0, AMONone, 32'h0, 4'hF, w);
    send(BASE + 32'h14, 1'b0, AMONone, 32'h0, 4'hF, w);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp.p_valid !== 1'b0 || rsp.q_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop got v=%b rdy=%b required 0 0",
               rsp.p_valid, rsp.q_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req.p_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp.p_valid !== 1'b0 || rsp.q_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_stale[%0d] got v=%b rdy=%b required 0 1",
                 c, rsp.p_valid, rsp.q_ready);
      end
      @(posedge clk);
      #1;
    end
    send(BASE + 32'h40, 1'b0, AMONone, 32'h0, 4'hF, w);
    @(negedge clk);
    checks++;
    if (rsp.p_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_resume got v=%b required 1", rsp.p_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_scoreboard();
    int n;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sb_count got %0d responses required %0d",
               obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sb_rsp[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < accx_q.size(); i++) begin
      checks++;
      if (acco_q[i].req !== accx_q[i].req
          || (accx_q[i].req && (acco_q[i].we !== accx_q[i].we
              || acco_q[i].addr !== accx_q[i].addr
              || acco_q[i].be !== accx_q[i].be
              || (accx_q[i].we && acco_q[i].wdata !== accx_q[i].wdata)))) begin
        errors++;
        $display("FAIL sb_mem[%0d] got %h required %h", i, acco_q[i], accx_q[i]);
      end
    end
    checks++;
    if (unstable_n != 0) begin
      errors++; $display("FAIL p_stable got %0d changes required 0", unstable_n);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_read();
    test_strobe();
    test_streaming();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_mid();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
